// File: rtl/index_slot_arbiter.sv
// index_slot_arbiter
//   Shares one index buffer (slot pool of SIZE entries) between NUM_REQS
//   requesters. A round-robin arbiter picks at most one requester per cycle,
//   drives the buffer's acquire/write port and returns the allocated slot
//   index as the requester's tag. The owner of every slot is recorded, and
//   each requester may hold at most MAX_PENDING slots. A flush/drain
//   sequence stops allocation and reports when the pool is fully released.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-requester allocation handshake
//   req_data          per-requester payload, requester i at [i*DATAW +: DATAW]
//   req_tag           slot index of this cycle's fire (= buf_write_addr)
//   rel_valid/addr    slot release strobe and slot index
//   rel_owner         recorded owner of rel_addr (combinational lookup)
//   buf_*             connection to the index buffer
//   flush/flush_done  drain request (level) and pool-released indication
//   dbg_state         current FSM state (RUN=0, DRAIN=1, DONE=2)
//   perf_*            stall/allocation counters, only with
//                     INDEX_SLOT_ARBITER_PERF_EN defined
//
// Handshake: a request fires in the cycle where req_valid[i] & req_ready[i]
// are both high. req_ready is a combinational function of req_valid and may
// drop while valid is held; a requester keeps valid and data stable until it
// fires. At most one req_ready bit is high in any cycle.
module index_slot_arbiter #(
   parameter int NUM_REQS    = 4,
   parameter int DATAW       = 32,
   parameter int SIZE        = 16,
   parameter int MAX_PENDING = 8,
   parameter int ADDRW       = (SIZE > 1) ? $clog2(SIZE) : 1,
   parameter int REQW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   parameter int CNTW        = $clog2(MAX_PENDING + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic [ADDRW-1:0]          req_tag,
   input  logic                      rel_valid,
   input  logic [ADDRW-1:0]          rel_addr,
   output logic [REQW-1:0]           rel_owner,
   output logic                      buf_acquire,
   output logic [DATAW-1:0]          buf_wdata,
   output logic                      buf_release,
   output logic [ADDRW-1:0]          buf_release_addr,
   input  logic [ADDRW-1:0]          buf_write_addr,
   input  logic                      buf_full,
   input  logic                      buf_empty,
   input  logic                      flush,
   output logic [1:0]                dbg_state,
   output logic                      flush_done
`ifdef INDEX_SLOT_ARBITER_PERF_EN
   ,
   output logic [31:0]               perf_stall_cycles,
   output logic [31:0]               perf_alloc_count
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [REQW-1:0] rr_q, rr_d;
   logic [CNTW-1:0] cnt_q [NUM_REQS];
   logic [CNTW-1:0] cnt_d [NUM_REQS];
   logic [REQW-1:0] owner_q [SIZE];
   logic [REQW-1:0] owner_d [SIZE];

   logic            can_grant;
   logic            fire;
   logic [REQW-1:0] winner;
   logic [REQW:0]   cand;
   logic            cnt_zero;

   // Round-robin search starting at rr_q; flush blocks grants in the same
   // cycle it is raised, not only once the FSM has moved to DRAIN.
   always_comb begin
      can_grant = !reset && (state_q == ST_RUN) && !flush && !buf_full;
      fire      = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         cand = {1'b0, rr_q} + (REQW+1)'(i);
         if (cand >= (REQW+1)'(NUM_REQS)) cand = cand - (REQW+1)'(NUM_REQS);
         if (!fire && can_grant && req_valid[cand[REQW-1:0]] &&
             (cnt_q[cand[REQW-1:0]] < CNTW'(MAX_PENDING))) begin
            fire   = 1'b1;
            winner = cand[REQW-1:0];
         end
      end
   end

   assign req_ready        = fire ? (NUM_REQS'(1) << winner) : '0;
   assign buf_acquire      = fire;
   assign buf_wdata        = req_data[int'(winner)*DATAW +: DATAW];
   assign req_tag          = buf_write_addr;
   assign buf_release      = rel_valid;
   assign buf_release_addr = rel_addr;
   assign rel_owner        = owner_q[rel_addr];
   assign dbg_state        = state_q;
   assign flush_done       = !reset && (state_q == ST_DONE) && flush;

   // Owner table, outstanding counters and round-robin pointer. An acquire
   // and a release by the same requester in one cycle cancel out.
   always_comb begin
      owner_d = owner_q;
      rr_d    = rr_q;
      if (fire) begin
         owner_d[buf_write_addr] = winner;
         rr_d = (winner == REQW'(NUM_REQS - 1)) ? '0 : winner + REQW'(1);
      end
      cnt_zero = 1'b1;
      for (int i = 0; i < NUM_REQS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_q[i] != '0) cnt_zero = 1'b0;
         if ((fire && winner == REQW'(i)) && !(rel_valid && rel_owner == REQW'(i)))
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         else if (!(fire && winner == REQW'(i)) && (rel_valid && rel_owner == REQW'(i)))
            cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
   end

   // Flush FSM. Dropping flush always returns to RUN; DONE needs both the
   // buffer's registered empty flag and no slot recorded as outstanding.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (flush) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!flush)                    state_d = ST_RUN;
            else if (buf_empty && cnt_zero) state_d = ST_DONE;
         end
         ST_DONE:  if (!flush) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         rr_q    <= '0;
         for (int i = 0; i < NUM_REQS; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
      // Owner entries are only meaningful while a slot is held; no reset.
      owner_q <= owner_d;
   end

`ifdef INDEX_SLOT_ARBITER_PERF_EN
   logic [31:0] stall_q, stall_d, alloc_q, alloc_d;

   always_comb begin
      stall_d = stall_q;
      alloc_d = alloc_q;
      if (fire && (alloc_q != '1))                      alloc_d = alloc_q + 32'd1;
      if (!fire && (|req_valid) && (stall_q != '1))     stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         alloc_q <= '0;
      end else begin
         stall_q <= stall_d;
         alloc_q <= alloc_d;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_alloc_count  = alloc_q;
`endif

   // Protocol and consistency checks.
   a_rel_in_reset: assert property (@(posedge clk) !(reset && rel_valid));
   a_rel_underflow: assert property (@(posedge clk) disable iff (reset)
      rel_valid |-> (cnt_q[rel_owner] != '0));
   a_cnt_overflow: assert property (@(posedge clk) disable iff (reset)
      (fire && !(rel_valid && rel_owner == winner)) |-> (cnt_q[winner] != CNTW'(MAX_PENDING)));

endmodule

// File: tb/tb_index_slot_arbiter.sv
// tb_index_slot_arbiter
//   Bench for index_slot_arbiter with default parameters. Contains a small
//   behavioural index buffer (lowest free slot is handed out, full/empty come
//   from registered occupancy) and a reference model of the arbiter kept as
//   plain integers: per-requester holdings, slot owners, round-robin start
//   and flush phase. Every cycle the DUT outputs are compared with the model.
module tb_index_slot_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int SZ = 16;
   localparam int MP = 8;
   localparam int AW = 4;
   localparam int RW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [AW-1:0]    req_tag;
   logic             rel_valid;
   logic [AW-1:0]    rel_addr;
   logic [RW-1:0]    rel_owner;
   logic             buf_acquire;
   logic [DW-1:0]    buf_wdata;
   logic             buf_release;
   logic [AW-1:0]    buf_release_addr;
   logic [AW-1:0]    buf_write_addr;
   logic             buf_full;
   logic             buf_empty;
   logic             flush;
   logic [1:0]       dbg_state;
   logic             flush_done;
`ifdef INDEX_SLOT_ARBITER_PERF_EN
   logic [31:0]      perf_stall_cycles;
   logic [31:0]      perf_alloc_count;
`endif

   index_slot_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .req_tag          (req_tag),
      .rel_valid        (rel_valid),
      .rel_addr         (rel_addr),
      .rel_owner        (rel_owner),
      .buf_acquire      (buf_acquire),
      .buf_wdata        (buf_wdata),
      .buf_release      (buf_release),
      .buf_release_addr (buf_release_addr),
      .buf_write_addr   (buf_write_addr),
      .buf_full         (buf_full),
      .buf_empty        (buf_empty),
      .flush            (flush),
      .dbg_state        (dbg_state),
`ifdef INDEX_SLOT_ARBITER_PERF_EN
      .perf_stall_cycles(perf_stall_cycles),
      .perf_alloc_count (perf_alloc_count),
`endif
      .flush_done       (flush_done)
   );

   // ---------------- index buffer environment ----------------
   logic [SZ-1:0] used;
   always @(posedge clk) begin
      if (reset) used <= '0;
      else begin
         if (buf_release) used[buf_release_addr] <= 1'b0;
         if (buf_acquire) used[buf_write_addr]   <= 1'b1;
      end
   end
   always_comb begin
      buf_write_addr = '0;
      for (int i = SZ - 1; i >= 0; i--) if (!used[i]) buf_write_addr = AW'(i);
   end
   assign buf_full  = &used;
   assign buf_empty = ~|used;

   // ---------------- reference model / scoreboard ----------------
   int          st_m = -1;      // -1 until first reset, then 0 RUN, 1 DRAIN, 2 DONE
   int          rr_m;
   int          cnt_m [NR];
   int          own_m [SZ];
   logic [31:0] stall_m, alloc_m;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already applied; check outputs mid-cycle,
   // then advance the model across the rising edge.
   task automatic step();
      logic [NR-1:0] exp_ready;
      bit            fire;
      int            win;
      bit            zero;
      logic [AW-1:0] wa, ra;
      bit            emp, fl, rs, rv, anyv;
      #2;
      exp_ready = '0;
      fire      = 0;
      win       = 0;
      if (!reset && st_m == 0 && !flush && !buf_full) begin
         for (int k = 0; k < NR; k++) begin
            int r;
            r = (rr_m + k) % NR;
            if (!fire && req_valid[r] && cnt_m[r] < MP) begin
               fire = 1;
               win  = r;
            end
         end
      end
      if (fire) exp_ready[win] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("buf_acquire", 64'(buf_acquire), 64'(fire));
      if (fire) begin
         check("buf_wdata", 64'(buf_wdata), 64'(req_data[win*DW +: DW]));
         check("req_tag", 64'(req_tag), 64'(buf_write_addr));
      end
      check("buf_release", 64'(buf_release), 64'(rel_valid));
      if (rel_valid) begin
         check("buf_release_addr", 64'(buf_release_addr), 64'(rel_addr));
         check("rel_owner", 64'(rel_owner), 64'(own_m[rel_addr]));
      end
      check("flush_done", 64'(flush_done), 64'(!reset && st_m == 2 && flush));
      if (st_m >= 0) begin
         check("state", 64'(dbg_state), 64'(st_m));
`ifdef INDEX_SLOT_ARBITER_PERF_EN
         check("perf_stall_cycles", 64'(perf_stall_cycles), 64'(stall_m));
         check("perf_alloc_count", 64'(perf_alloc_count), 64'(alloc_m));
`endif
      end
      wa = buf_write_addr; ra = rel_addr; emp = buf_empty; fl = flush;
      rs = reset; rv = rel_valid; anyv = |req_valid;
      @(posedge clk);
      if (rs) begin
         st_m = 0; rr_m = 0; stall_m = '0; alloc_m = '0;
         for (int k = 0; k < NR; k++) cnt_m[k] = 0;
      end else begin
         zero = 1;
         for (int k = 0; k < NR; k++) if (cnt_m[k] != 0) zero = 0;
         if (rv) cnt_m[own_m[ra]]--;
         if (fire) begin
            cnt_m[win]++;
            own_m[wa] = win;
            rr_m = (win + 1) % NR;
         end
         case (st_m)
            0: if (fl) st_m = 1;
            1: if (!fl) st_m = 0; else if (emp && zero) st_m = 2;
            2: if (!fl) st_m = 0;
            default: ;
         endcase
         if (fire) begin
            if (alloc_m != '1) alloc_m++;
         end else if (anyv) begin
            if (stall_m != '1) stall_m++;
         end
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic rand_data();
      for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = $urandom();
   endtask

   function automatic int pick_used();
      int s;
      s = $urandom_range(0, SZ - 1);
      for (int k = 0; k < SZ; k++) if (used[(s + k) % SZ]) return (s + k) % SZ;
      return -1;
   endfunction

   task automatic run(input int n);
      repeat (n) begin
         rand_data();
         step();
      end
   endtask

   task automatic do_release(input int addr);
      rel_valid = 1'b1;
      rel_addr  = AW'(addr);
      rand_data();
      step();
      rel_valid = 1'b0;
   endtask

   task automatic release_all();
      for (int k = 0; k < SZ; k++) begin
         int p;
         p = pick_used();
         if (p >= 0) do_release(p);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; req_valid = '1; req_data = '0;
      rel_valid = 1'b0; rel_addr = '0; flush = 1'b0;
      run(2);                             // grants held off during reset
      reset = 1'b0; req_valid = '0;
      run(1);

      // All requesters: round-robin order, tags 0..15, then pool full.
      req_valid = '1;
      run(20);
      req_valid = '0;
      release_all();

      // Requester 2 alone up to its cap, release slot 3, one more grant.
      req_valid = 4'b0100;
      run(10);
      do_release(3);
      run(3);
      req_valid = '0;
      release_all();

      // Same-cycle acquire/release, same and different requesters.
      req_valid = 4'b0010;
      run(2);
      do_release(0);                      // req 1 acquires while releasing
      req_valid = 4'b1000;
      run(1);
      req_valid = 4'b0001;
      do_release(0);                      // req 0 acquires, req 3 releases
      req_valid = '0;
      release_all();
      req_valid = 4'b1001;
      run(10);                            // counters observed via caps
      req_valid = '0;
      release_all();

      // Flush with 5 slots held.
      req_valid = '1;
      run(5);
      flush = 1'b1;
      run(2);
      release_all();
      run(3);
      flush = 1'b0;
      run(2);
      req_valid = '0;
      release_all();

      // Reset while draining with 3 slots held.
      req_valid = '1;
      run(3);
      req_valid = '0;
      flush = 1'b1;
      run(2);
      reset = 1'b1;
      run(1);
      reset = 1'b0; flush = 1'b0; req_valid = '1;
      run(4);
      req_valid = '0;
      release_all();

      // Requester 0 against a full pool, then two fires.
      req_valid = '1;
      run(17);
      req_valid = 4'b0001;
      run(10);
      do_release(pick_used());
      do_release(pick_used());
      run(3);
      req_valid = '0;
      release_all();

      // Randomized traffic with flush toggles and occasional resets.
      for (int c = 0; c < 500; c++) begin
         int p;
         req_valid = NR'($urandom_range(0, (1 << NR) - 1));
         rel_valid = 1'b0;
         reset     = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 9) == 0) flush = ~flush;
         if (!reset && $urandom_range(0, 2) == 0) begin
            p = pick_used();
            if (p >= 0) begin
               rel_valid = 1'b1;
               rel_addr  = AW'(p);
            end
         end
         rand_data();
         step();
      end
      reset = 1'b0; rel_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
